// File: rtl/traffic_phase_timer.sv
// Phase pacing and emergency preemption for the four-way light controller.
// Counts green/yellow dwell, emits one-cycle step pulses to advance the
// downstream light FSM, and one-cycle force pulses to jump it to a green.
//
// state  | meaning
// GREEN  | cur_dir green, dwell counting, requests evaluated
// YELLOW | cur_dir yellow, target locked, dwell counting
// HOLD   | cur_dir green held while its own emergency request is high
module traffic_phase_timer #(
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 5,
  parameter int MIN_GREEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       req_n_i,
  input  logic       req_e_i,
  input  logic       req_s_i,
  input  logic       req_w_i,
  output logic       step_o,
  output logic       force_n_o,
  output logic       force_e_o,
  output logic       force_s_o,
  output logic       force_w_o,
  output logic [1:0] cur_dir_o,
  output logic       in_yellow_o,
  output logic       preempt_active_o
);

  localparam logic [15:0] GREEN_LAST  = 16'(GREEN_CYCLES - 1);
  localparam logic [15:0] YELLOW_LAST = 16'(YELLOW_CYCLES - 1);
  localparam logic [15:0] MIN_LAST    = 16'(MIN_GREEN - 1);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  tgt_q, tgt_d;
  logic        pre_q, pre_d;
  logic [1:0]  cur_dir_q, cur_dir_d;
  logic        pa_q, pa_d;
  logic        step_q, step_d;
  logic [3:0]  force_q, force_d;

  logic [3:0]  req;
  logic        sel_vld;
  logic [1:0]  sel;

  assign req     = {req_w_i, req_s_i, req_e_i, req_n_i};
  assign sel_vld = |req;

  // Fixed priority N > E > S > W.
  always_comb begin
    sel = 2'd3;
    if (req[0])      sel = 2'd0;
    else if (req[1]) sel = 2'd1;
    else if (req[2]) sel = 2'd2;
  end

  // Next-state, counter and pulse decode; nothing moves while en_i is low.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    pre_d     = pre_q;
    cur_dir_d = cur_dir_q;
    pa_d      = pa_q;
    step_d    = 1'b0;
    force_d   = 4'b0000;
    if (en_i) begin
      case (state_q)
        GREEN: begin
          if (sel_vld && sel == cur_dir_q) begin
            state_d = HOLD;
            pa_d    = 1'b1;
            cnt_d   = 16'd0;
          end else if (sel_vld && cnt_q >= MIN_LAST) begin
            step_d  = 1'b1;
            tgt_d   = sel;
            pre_d   = 1'b1;
            pa_d    = 1'b1;
            cnt_d   = 16'd0;
            state_d = YELLOW;
          end else if (!sel_vld && cnt_q == GREEN_LAST) begin
            step_d  = 1'b1;
            tgt_d   = cur_dir_q + 2'd1;
            pre_d   = 1'b0;
            pa_d    = 1'b0;
            cnt_d   = 16'd0;
            state_d = YELLOW;
          end else begin
            cnt_d = cnt_q + 16'd1;
            pa_d  = 1'b0;
          end
        end
        YELLOW: begin
          if (cnt_q == YELLOW_LAST) begin
            if (pre_q) force_d[tgt_q] = 1'b1;
            else       step_d = 1'b1;
            cur_dir_d = tgt_q;
            cnt_d     = 16'd0;
            pre_d     = 1'b0;
            state_d   = GREEN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        HOLD: begin
          if (!req[cur_dir_q]) begin
            state_d = GREEN;
            cnt_d   = 16'd0;
            pa_d    = 1'b0;
          end
        end
        default: state_d = GREEN;
      endcase
    end
  end

  // State and registered outputs; rst_n is active-high asynchronous.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= GREEN;
      cnt_q     <= 16'd0;
      tgt_q     <= 2'd0;
      pre_q     <= 1'b0;
      cur_dir_q <= 2'd0;
      pa_q      <= 1'b0;
      step_q    <= 1'b0;
      force_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      pre_q     <= pre_d;
      cur_dir_q <= cur_dir_d;
      pa_q      <= pa_d;
      step_q    <= step_d;
      force_q   <= force_d;
    end
  end

  assign step_o           = step_q;
  assign force_n_o        = force_q[0];
  assign force_e_o        = force_q[1];
  assign force_s_o        = force_q[2];
  assign force_w_o        = force_q[3];
  assign cur_dir_o        = cur_dir_q;
  assign in_yellow_o      = (state_q == YELLOW);
  assign preempt_active_o = pa_q;

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Upstream pacing and preemption stage for the four-way traffic light controller. It counts green and yellow dwell times and emits a one-cycle `step` pulse each time the downstream light FSM must advance. It also converts emergency-vehicle requests into one-cycle `force_*` pulses that drive the FSM's per-direction reset inputs. The block tracks the light phase internally, so the downstream FSM never needs to report back.

## Interface
- GREEN_CYCLES, 20: normal green dwell in clk cycles; legal range 1..65535.
- YELLOW_CYCLES, 5: yellow dwell in clk cycles; legal range 1..65535.
- MIN_GREEN, 4: minimum green time before preemption may cut a green short; legal range 1..GREEN_CYCLES.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; when low, the counter and state freeze and no pulses are emitted.
- req_n, req_e, req_s, req_w  in  1 each  emergency requests, level, already synchronous to clk.
- step  out  1  one-cycle pulse: advance the downstream FSM by one state.
- force_n, force_e, force_s, force_w  out  1 each  one-cycle pulse: jump the downstream FSM to that direction's green.
- cur_dir  out  2  direction currently green or yellow: 0=N, 1=E, 2=S, 3=W.
- in_yellow  out  1  high during a yellow phase.
- preempt_active  out  1  high from acceptance of a preemption until the preempted green is released.

## Operation
- States: GREEN, YELLOW, HOLD. Internal registers: a 16-bit counter `cnt`, a 2-bit target `tgt`, and a flag `pre` marking that the target came from a preemption.
- Reset values: state=GREEN, cur_dir=0, cnt=0, tgt=0, pre=0. All outputs are 0 (step, all force_*, cur_dir, in_yellow, preempt_active).
- Request selection: fixed priority N > E > S > W among asserted requests. Selection is evaluated only in GREEN.

**GREEN** (cnt increments each enabled cycle). Rules are checked in this order:
  1. Selected request equals cur_dir: go to HOLD with no pulse and set preempt_active=1.
  2. Selected request differs from cur_dir and cnt ≥ MIN_GREEN−1: emit step, set tgt=request, pre=1, preempt_active=1, cnt=0, and go to YELLOW.
  3. No request and cnt == GREEN_CYCLES−1: emit step, set tgt=cur_dir+1 (mod 4), pre=0, cnt=0, and go to YELLOW.

**YELLOW** (in_yellow=1; cnt increments):
- New requests are ignored and tgt is locked.
- At cnt == YELLOW_CYCLES−1: if pre=0, emit step; if pre=1, emit force_<tgt> and no step. In both cases set cur_dir=tgt, cnt=0, go to GREEN, and clear pre.

**HOLD** (green held; no pulses):
- Exit when req[cur_dir] is low: go to GREEN with cnt=0 and preempt_active=0.
- Requests for other directions stay pending and are served through the GREEN rules after MIN_GREEN.

**General rules**
- Preemption always passes through a full YELLOW_CYCLES yellow. A green is never cut directly to another green.
- step and force_* are never high in the same cycle. At most one force_* is high at a time.
- When en is low, all registers hold and step/force_* are 0. Pulses resume on the first enabled cycle.

## Timing
- All outputs are registered. step/force_* update on the same edge as cur_dir, in_yellow and the state change.
- Normal rotation:
  - Pulses occur every GREEN_CYCLES cycles (green→yellow) and then YELLOW_CYCLES cycles later (yellow→green).
  - Full cycle through all four directions = 4·(GREEN_CYCLES+YELLOW_CYCLES).
- Preemption latency: from a request's first high cycle to force_<dir> is at most max(MIN_GREEN − cnt, 1) + YELLOW_CYCLES cycles when the request arrives in GREEN.
- A request arriving during YELLOW is evaluated on the first GREEN cycle.
- A request that drops before acceptance is forgotten. Once a preemption is accepted in GREEN, it completes regardless of the request level.
- Asynchronous reset at any point (including mid-YELLOW or in HOLD) returns all state and outputs to reset values immediately. The next step occurs GREEN_CYCLES enabled cycles after reset release.
- Counter width is 16 bits. Parameter values must fit, so the counter never wraps.

## Test plan
- **Normal rotation** (G=20, Y=5, no requests, en=1):
  - step pulses occur at cycles 20, 25, 45, 50, …
  - cur_dir sequence is 0,1,2,3,0.
  - in_yellow is high during cycles 20..24.
- **Early preemption** (req_s raised at cnt=1 while N green, MIN_GREEN=4):
  - step when cnt reaches 3, then 5 yellow cycles.
  - force_s pulses once, cur_dir=2, no step in that cycle.
- **Hold then release** (req_e raised while E green, held 100 cycles):
  - No pulses for 100 cycles; HOLD with preempt_active=1.
  - After drop, the next step comes 20 cycles later.
- **Priority** (req_w and req_e raised together while N green):
  - force_e fires first.
  - W is served after E's MIN_GREEN if req_w is still high.
- **en gating** (en low for 7 cycles mid-green): the next step is delayed by exactly 7 cycles and no pulses occur while en is low.
- **Reset mid-yellow** (rst_n pulsed at yellow cnt=2):
  - Outputs immediately 0, cur_dir=0, in_yellow=0.
  - First step 20 cycles after release.
